aes_enc_stream_ctrl: RTL and testbench

AES_ENC_STREAM_CTRL -- requirements
Module: aes_enc_stream_ctrl

---
 rtl/aes_stream_pkg.sv | 14 +
 rtl/aes_stream_fifo.sv | 65 ++++++
 rtl/aes_enc_stream_ctrl.sv | 94 +++++++++
 tb/tb_aes_enc_stream_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_stream_pkg.sv
// Shared defaults and the result-FIFO entry layout for the AES stream controller.
package aes_stream_pkg;

   localparam int BLOCK_LENGTH = 128;
   localparam int PIPE_DEPTH   = 11;
   localparam int FIFO_DEPTH   = 16;
   localparam int TAG_W        = 8;

   typedef struct packed {
      logic [BLOCK_LENGTH-1:0] ct;
      logic [TAG_W-1:0]        tag;
   } fifo_entry_t;

endpackage

// File: rtl/aes_stream_fifo.sv
// Show-ahead synchronous FIFO holding {ciphertext, tag} results until downstream pops them.
module aes_stream_fifo
   import aes_stream_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH,
   parameter int W     = $bits(fifo_entry_t)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         not_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_wr, do_rd;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign not_empty = (cnt_q != '0);
   assign do_rd     = rd_en && not_empty;
   // A write into a full FIFO is dropped; upstream credit keeps this from happening.
   assign do_wr     = wr_en && ((cnt_q != CW'(DEPTH)) || do_rd);
   assign rd_data   = not_empty ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      wr_ptr_d = do_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_wr && !do_rd) begin
         cnt_d = cnt_q + CW'(1);
      end else if (do_rd && !do_wr) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/aes_enc_stream_ctrl.sv
// Valid/ready wrapper around a free-running AES_enc pipeline: tracks in-flight blocks,
// captures results into a FIFO and grants upstream credit from total occupancy.
module aes_enc_stream_ctrl #(
   parameter int BLOCK_LENGTH = aes_stream_pkg::BLOCK_LENGTH,
   parameter int PIPE_DEPTH   = aes_stream_pkg::PIPE_DEPTH,
   parameter int FIFO_DEPTH   = aes_stream_pkg::FIFO_DEPTH,
   parameter int TAG_W        = aes_stream_pkg::TAG_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [BLOCK_LENGTH-1:0] s_pt,
   input  logic [BLOCK_LENGTH-1:0] s_key,
   input  logic [TAG_W-1:0]        s_tag,
   output logic [BLOCK_LENGTH-1:0] aes_in,
   output logic [BLOCK_LENGTH-1:0] aes_key,
   output logic                    aes_enable,
   input  logic [BLOCK_LENGTH-1:0] aes_out,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [BLOCK_LENGTH-1:0] m_ct,
   output logic [TAG_W-1:0]        m_tag,
   output logic [31:0]             blk_count
);

   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

   logic [PIPE_DEPTH-1:0] vld_q, vld_d;
   logic [TAG_W-1:0]      tag_q [PIPE_DEPTH];
   logic [TAG_W-1:0]      tag_d [PIPE_DEPTH];
   logic [OCC_W-1:0]      occ_q, occ_d;
   logic [31:0]           blk_cnt_q, blk_cnt_d;
   logic                  accept, pop;
   logic                  fifo_not_empty;

   // occ counts in-flight plus queued blocks, so the FIFO always has room for every
   // block still inside AES_enc.
   assign s_ready    = rst && (occ_q < OCC_W'(FIFO_DEPTH));
   assign accept     = s_valid && s_ready;
   assign pop        = m_valid && m_ready;
   assign aes_in     = s_pt;
   assign aes_key    = s_key;
   assign aes_enable = rst;
   assign m_valid    = fifo_not_empty;
   assign blk_count  = blk_cnt_q;

   always_comb begin
      vld_d    = {vld_q[PIPE_DEPTH-2:0], accept};
      tag_d[0] = s_tag;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
         tag_d[i] = tag_q[i-1];
      end
      occ_d = occ_q;
      case ({accept, pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
      blk_cnt_d = pop ? blk_cnt_q + 32'd1 : blk_cnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q     <= '0;
         occ_q     <= '0;
         blk_cnt_q <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         vld_q     <= vld_d;
         occ_q     <= occ_d;
         blk_cnt_q <= blk_cnt_d;
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   aes_stream_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (BLOCK_LENGTH + TAG_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst),
      .wr_en     (vld_q[PIPE_DEPTH-1]),
      .wr_data   ({aes_out, tag_q[PIPE_DEPTH-1]}),
      .rd_en     (m_ready),
      .rd_data   ({m_ct, m_tag}),
      .not_empty (fifo_not_empty)
   );

endmodule

// File: tb/tb_aes_enc_stream_ctrl.sv
// Bench for aes_enc_stream_ctrl: behavioural AES_enc pipeline stub plus a queue-based scoreboard.
module tb_aes_enc_stream_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         s_valid, s_ready;
   logic [127:0] s_pt, s_key;
   logic [7:0]   s_tag;
   logic [127:0] aes_in, aes_key, aes_out;
   logic         aes_enable;
   logic         m_valid, m_ready;
   logic [127:0] m_ct;
   logic [7:0]   m_tag;
   logic [31:0]  blk_count;

   always #5 clk = ~clk;

   aes_enc_stream_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_pt       (s_pt),
      .s_key      (s_key),
      .s_tag      (s_tag),
      .aes_in     (aes_in),
      .aes_key    (aes_key),
      .aes_enable (aes_enable),
      .aes_out    (aes_out),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_ct       (m_ct),
      .m_tag      (m_tag),
      .blk_count  (blk_count)
   );

   logic [7:0] sbox [256];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p  = 8'h00;
      logic [7:0] aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xt(aa);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d = {b, b};
      d = d >> (8 - n);
      return d[7:0];
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] p = 8'h01;
         logic [7:0] xb = 8'(x);
         for (int k = 0; k < 254; k++) p = gmul(p, xb);
         sbox[x] = p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3) ^ rotl8(p, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
      logic [31:0]  w [44];
      logic [7:0]   st [16];
      logic [7:0]   t [16];
      logic [31:0]  tmp;
      logic [7:0]   rc = 8'h01;
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
            rc  = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox[st[i]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) st[rr + 4*c] = t[rr + 4*((c + rr) % 4)];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
               st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
      return res;
   endfunction

   // AES_enc stand-in: 11 register stages, frozen while disabled (keeps stale contents).
   logic [127:0] pipe [11];
   always @(posedge clk) begin
      if (aes_enable) begin
         pipe[0] <= aes_ref(aes_in, aes_key);
         for (int i = 1; i < 11; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign aes_out = pipe[10];

   typedef struct {
      logic [127:0] ct;
      logic [7:0]   tag;
      int           rdy;
   } exp_t;

   exp_t         q[$];
   int           cyc = 0;
   logic [31:0]  blk_exp = 32'd0;
   int           n_cmp = 0;
   int           n_err = 0;
   logic         last_mv;
   logic [127:0] last_ct;
   logic [7:0]   last_tag;
   int           n_acc_dut = 0;

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive at the falling edge, check, then advance the reference on the rising edge.
   task automatic step(input logic r, input logic sv, input logic mr,
                       input logic [127:0] pt, input logic [127:0] key, input logic [7:0] tg);
      logic exp_rdy, exp_mv, acc, pp;
      rst = r; s_valid = sv; m_ready = mr; s_pt = pt; s_key = key; s_tag = tg;
      if (!r) begin
         q.delete();
         blk_exp = 32'd0;
      end
      #1;
      exp_rdy = r && (q.size() < 16);
      exp_mv  = r && (q.size() > 0) && (q[0].rdy <= cyc);
      check_val("s_ready",    128'(s_ready),    128'(exp_rdy));
      check_val("m_valid",    128'(m_valid),    128'(exp_mv));
      check_val("aes_enable", 128'(aes_enable), 128'(r));
      check_val("blk_count",  128'(blk_count),  128'(blk_exp));
      check_val("aes_in",     aes_in,  pt);
      check_val("aes_key",    aes_key, key);
      if (exp_mv) begin
         check_val("m_ct",  m_ct,         q[0].ct);
         check_val("m_tag", 128'(m_tag),  128'(q[0].tag));
      end else if (!r) begin
         check_val("m_ct_rst",  m_ct,        128'h0);
         check_val("m_tag_rst", 128'(m_tag), 128'h0);
      end
      last_mv  = m_valid;
      last_ct  = m_ct;
      last_tag = m_tag;
      if (s_valid && s_ready) n_acc_dut++;
      acc = sv && exp_rdy;
      pp  = exp_mv && mr;
      @(posedge clk);
      cyc++;
      if (acc) q.push_back('{ct: aes_ref(pt, key), tag: tg, rdy: cyc + 11});
      if (pp) begin
         void'(q.pop_front());
         blk_exp++;
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic mr);
      step(1'b1, 1'b0, mr, 128'h0, 128'h0, 8'h00);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      int lat, first_k, last_k, n_mv;
      logic found;
      logic [127:0] kat_ct;
      logic [7:0]   kat_tag;

      build_sbox();
      rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      s_pt = '0; s_key = '0; s_tag = '0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, rnd128(), rnd128(), 8'hff);

      // Known-answer single block and its latency
      step(1'b1, 1'b1, 1'b1, 128'h00112233445566778899aabbccddeeff,
           128'h000102030405060708090a0b0c0d0e0f, 8'h01);
      found = 1'b0; lat = 0; kat_ct = '0; kat_tag = '0;
      for (int k = 1; k <= 30; k++) begin
         idle(1'b1);
         if (last_mv && !found) begin
            found = 1'b1; lat = k; kat_ct = last_ct; kat_tag = last_tag;
         end
      end
      check_val("kat_latency", 128'(lat), 128'(12));
      check_val("kat_ct", kat_ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      check_val("kat_tag", 128'(kat_tag), 128'h01);

      // Eleven back-to-back blocks, first one all-zero
      for (int i = 0; i < 11; i++)
         step(1'b1, 1'b1, 1'b1, (i == 0) ? 128'h0 : rnd128(), (i == 0) ? 128'h0 : rnd128(), 8'(i));
      n_mv = 0; first_k = -1; last_k = -1; kat_ct = '0; kat_tag = 8'hff;
      for (int k = 0; k < 25; k++) begin
         idle(1'b1);
         if (last_mv) begin
            if (first_k < 0) begin
               first_k = k; kat_ct = last_ct; kat_tag = last_tag;
            end
            last_k = k;
            n_mv++;
         end
      end
      check_val("b2b_count", 128'(n_mv), 128'(11));
      check_val("b2b_span", 128'(last_k - first_k), 128'(10));
      check_val("b2b_zero_ct", kat_ct, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
      check_val("b2b_first_tag", 128'(kat_tag), 128'h00);
      check_val("b2b_blk_count", 128'(blk_count), 128'(12));

      // Fill with downstream stalled, then pop and offer at the full boundary
      n_acc_dut = 0;
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, rnd128(), rnd128(), 8'(8'h20 + i));
      check_val("fill_accepts", 128'(n_acc_dut), 128'(16));
      step(1'b1, 1'b1, 1'b1, rnd128(), rnd128(), 8'h55);
      check_val("full_pop_accepts", 128'(n_acc_dut), 128'(16));
      step(1'b1, 1'b1, 1'b1, rnd128(), rnd128(), 8'h56);
      check_val("credit_return", 128'(n_acc_dut), 128'(17));
      for (int i = 0; i < 30; i++) idle(1'b1);

      // Reset while blocks are in flight
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, rnd128(), rnd128(), 8'(8'h40 + i));
      idle(1'b0);
      step(1'b0, 1'b0, 1'b1, 128'h0, 128'h0, 8'h00);
      step(1'b0, 1'b0, 1'b1, 128'h0, 128'h0, 8'h00);
      n_mv = 0;
      for (int i = 0; i < 20; i++) begin
         idle(1'b1);
         if (last_mv) n_mv++;
      end
      check_val("rst_no_valid", 128'(n_mv), 128'(0));
      check_val("rst_blk_count", 128'(blk_count), 128'(0));

      // Alternating bubbles
      for (int i = 0; i < 30; i++) step(1'b1, (i % 2 == 0), 1'b1, rnd128(), rnd128(), 8'(i));
      for (int i = 0; i < 15; i++) idle(1'b1);

      // Random traffic with varying backpressure and occasional reset
      for (int i = 0; i < 2000; i++) begin
         logic sv, mr, r;
         r  = ($urandom_range(0, 599) != 0);
         sv = ($urandom_range(0, 3) != 0);
         mr = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         step(r, sv, mr, rnd128(), rnd128(), 8'($urandom));
      end
      for (int i = 0; i < 40; i++) idle(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
